branch_resolve_unit: RTL and testbench

//  Execute-stage branch resolver; producer side of the branch_prediction update interface.

---
 rtl/branch_resolve_unit.sv | 239 +++++++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolver: evaluates branches/jumps, checks the fetch prediction,
// drives the predictor update, flush/redirect, and masks a shadow window after a mispredict.
// Optional performance counters are built only when BRU_PERF_CNT_EN is defined.
`timescale 1ns/1ps

module branch_resolve_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic [31:0]       pc_i,
    input  logic              is_branch_i,
    input  logic              is_jal_i,
    input  logic              is_jalr_i,
    input  logic [2:0]        funct3_i,
    input  logic [4:0]        rs1_idx_i,
    input  logic [4:0]        rd_idx_i,
    input  logic [31:0]       rs1_data_i,
    input  logic [31:0]       rs2_data_i,
    input  logic [31:0]       imm_i,
    input  logic              pred_taken_i,
    input  logic [31:0]       pred_pc_i,
    output logic              branch_request_o,
    output logic [31:0]       branch_source_o,
    output logic              branch_is_taken_o,
    output logic              branch_is_call_o,
    output logic              branch_is_ret_o,
    output logic              branch_is_jmp_o,
    output logic [31:0]       branch_target_o,
    output logic              branch_mispredict_o,
    output logic              flush_o,
    output logic [31:0]       redirect_pc_o,
    output logic [31:0]       link_data_o,
    output logic [CNT_W-1:0]  perf_branch_cnt_o,
    output logic [CNT_W-1:0]  perf_mispred_cnt_o
);

    localparam int SC_W = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {
        NORMAL = 1'b0,
        SHADOW = 1'b1
    } state_t;

    function automatic logic cond_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

    function automatic logic cond_true(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return sa < sb;
            3'b101:  return sa >= sb;
            3'b110:  return a < b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_link_reg(input logic [4:0] idx);
        return (idx == 5'd1) || (idx == 5'd5);
    endfunction

    state_t            state_q, state_d;
    logic [SC_W-1:0]   shadow_cnt_q, shadow_cnt_d;

    logic              request_q, request_d;
    logic [31:0]       source_q, source_d;
    logic              taken_q, taken_d;
    logic              call_q, call_d;
    logic              ret_q, ret_d;
    logic              jmp_q, jmp_d;
    logic [31:0]       target_q, target_d;
    logic              mispredict_q, mispredict_d;
    logic [31:0]       redirect_q, redirect_d;
    logic [31:0]       link_q, link_d;

    logic              one_op;
    logic              accept;
    logic              res_taken;
    logic [31:0]       res_target;
    logic [31:0]       jalr_sum;
    logic [31:0]       fall_pc;
    logic              res_call;
    logic              res_ret;
    logic              res_jmp;
    logic              res_mispredict;

    // Combinational resolve of the instruction currently on the inputs
    always_comb begin
        one_op     = (is_branch_i ^ is_jal_i ^ is_jalr_i) & ~(is_branch_i & is_jal_i & is_jalr_i);
        accept     = valid_i & ~stall_i & (state_q == NORMAL) & one_op
                     & (~is_branch_i | cond_legal(funct3_i));
        res_taken  = is_branch_i ? cond_true(funct3_i, rs1_data_i, rs2_data_i) : 1'b1;
        jalr_sum   = rs1_data_i + imm_i;
        fall_pc    = pc_i + 32'd4;
        res_target = is_jalr_i ? {jalr_sum[31:1], 1'b0} : (pc_i + imm_i);
        res_call   = (is_jal_i | is_jalr_i) & is_link_reg(rd_idx_i);
        res_ret    = is_jalr_i & is_link_reg(rs1_idx_i) & ~is_link_reg(rd_idx_i);
        res_jmp    = (is_jal_i | is_jalr_i) & ~res_call & ~res_ret;
        res_mispredict = (res_taken != pred_taken_i)
                       | (res_taken & (pred_pc_i != res_target));
    end

    always_comb begin
        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        case (state_q)
            NORMAL: begin
                if (accept && res_mispredict) begin
                    state_d      = SHADOW;
                    shadow_cnt_d = SC_W'(FLUSH_CYCLES);
                end
            end
            SHADOW: begin
                // Wrong-path slots drain only while the pipeline advances
                if (!stall_i) begin
                    shadow_cnt_d = shadow_cnt_q - SC_W'(1);
                    if (shadow_cnt_q == SC_W'(1)) begin
                        state_d = NORMAL;
                    end
                end
            end
            default: begin
                state_d      = NORMAL;
                shadow_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        request_d    = accept;
        mispredict_d = accept & res_mispredict;
        source_d     = source_q;
        taken_d      = taken_q;
        call_d       = call_q;
        ret_d        = ret_q;
        jmp_d        = jmp_q;
        target_d     = target_q;
        redirect_d   = redirect_q;
        link_d       = link_q;
        if (accept) begin
            source_d   = pc_i;
            taken_d    = res_taken;
            call_d     = res_call;
            ret_d      = res_ret;
            jmp_d      = res_jmp;
            target_d   = res_target;
            redirect_d = res_taken ? res_target : fall_pc;
            link_d     = fall_pc;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q      <= NORMAL;
            shadow_cnt_q <= '0;
            request_q    <= 1'b0;
            source_q     <= '0;
            taken_q      <= 1'b0;
            call_q       <= 1'b0;
            ret_q        <= 1'b0;
            jmp_q        <= 1'b0;
            target_q     <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            link_q       <= '0;
        end else begin
            state_q      <= state_d;
            shadow_cnt_q <= shadow_cnt_d;
            request_q    <= request_d;
            source_q     <= source_d;
            taken_q      <= taken_d;
            call_q       <= call_d;
            ret_q        <= ret_d;
            jmp_q        <= jmp_d;
            target_q     <= target_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            link_q       <= link_d;
        end
    end

    assign branch_request_o    = request_q;
    assign branch_source_o     = source_q;
    assign branch_is_taken_o   = taken_q;
    assign branch_is_call_o    = call_q;
    assign branch_is_ret_o     = ret_q;
    assign branch_is_jmp_o     = jmp_q;
    assign branch_target_o     = target_q;
    assign branch_mispredict_o = mispredict_q;
    assign flush_o             = mispredict_q;
    assign redirect_pc_o       = redirect_q;
    assign link_data_o         = link_q;

`ifdef BRU_PERF_CNT_EN
    logic [CNT_W-1:0] perf_branch_cnt_q, perf_branch_cnt_d;
    logic [CNT_W-1:0] perf_mispred_cnt_q, perf_mispred_cnt_d;

    // Counters advance on the same edge that raises the corresponding output pulse
    always_comb begin
        perf_branch_cnt_d  = perf_branch_cnt_q;
        perf_mispred_cnt_d = perf_mispred_cnt_q;
        if (accept) begin
            perf_branch_cnt_d = perf_branch_cnt_q + CNT_W'(1);
            if (res_mispredict) begin
                perf_mispred_cnt_d = perf_mispred_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            perf_branch_cnt_q  <= '0;
            perf_mispred_cnt_q <= '0;
        end else begin
            perf_branch_cnt_q  <= perf_branch_cnt_d;
            perf_mispred_cnt_q <= perf_mispred_cnt_d;
        end
    end

    assign perf_branch_cnt_o  = perf_branch_cnt_q;
    assign perf_mispred_cnt_o = perf_mispred_cnt_q;
`else
    assign perf_branch_cnt_o  = '0;
    assign perf_mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push expected updates,
// a negedge monitor pops and compares whenever branch_request_o is high.
`timescale 1ns/1ps

module tb_branch_resolve_unit;

    localparam int CNT_W = 32;
    localparam logic [1:0] K_BR   = 2'd0;
    localparam logic [1:0] K_JAL  = 2'd1;
    localparam logic [1:0] K_JALR = 2'd2;

    logic              clk_i = 1'b0;
    logic              n_rst_i;
    logic              valid_i, stall_i;
    logic [31:0]       pc_i;
    logic              is_branch_i, is_jal_i, is_jalr_i;
    logic [2:0]        funct3_i;
    logic [4:0]        rs1_idx_i, rd_idx_i;
    logic [31:0]       rs1_data_i, rs2_data_i, imm_i;
    logic              pred_taken_i;
    logic [31:0]       pred_pc_i;
    logic              branch_request_o;
    logic [31:0]       branch_source_o;
    logic              branch_is_taken_o, branch_is_call_o, branch_is_ret_o, branch_is_jmp_o;
    logic [31:0]       branch_target_o;
    logic              branch_mispredict_o, flush_o;
    logic [31:0]       redirect_pc_o, link_data_o;
    logic [CNT_W-1:0]  perf_branch_cnt_o, perf_mispred_cnt_o;

    branch_resolve_unit #(.FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .n_rst_i(n_rst_i), .valid_i(valid_i), .stall_i(stall_i),
        .pc_i(pc_i), .is_branch_i(is_branch_i), .is_jal_i(is_jal_i), .is_jalr_i(is_jalr_i),
        .funct3_i(funct3_i), .rs1_idx_i(rs1_idx_i), .rd_idx_i(rd_idx_i),
        .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .pred_taken_i(pred_taken_i), .pred_pc_i(pred_pc_i),
        .branch_request_o(branch_request_o), .branch_source_o(branch_source_o),
        .branch_is_taken_o(branch_is_taken_o), .branch_is_call_o(branch_is_call_o),
        .branch_is_ret_o(branch_is_ret_o), .branch_is_jmp_o(branch_is_jmp_o),
        .branch_target_o(branch_target_o), .branch_mispredict_o(branch_mispredict_o),
        .flush_o(flush_o), .redirect_pc_o(redirect_pc_o), .link_data_o(link_data_o),
        .perf_branch_cnt_o(perf_branch_cnt_o), .perf_mispred_cnt_o(perf_mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] src;
        logic        taken;
        logic        call;
        logic        ret;
        logic        jmp;
        logic [31:0] tgt;
        logic        mis;
        logic [31:0] redir;
        logic [31:0] link;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] src, input logic taken, input logic call,
                                input logic ret, input logic jmp, input logic [31:0] tgt,
                                input logic mis, input logic [31:0] redir, input logic [31:0] link);
        exp_t e;
        e.src = src; e.taken = taken; e.call = call; e.ret = ret; e.jmp = jmp;
        e.tgt = tgt; e.mis = mis; e.redir = redir; e.link = link;
        return e;
    endfunction

    // Monitor: compare every presented update against the oldest expectation
    always @(negedge clk_i) begin
        if (n_rst_i && branch_request_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_request: got request at pc 0x%08h, expected none",
                         branch_source_o);
            end else begin
                mon_e = sb_q.pop_front();
                chk("source", branch_source_o, mon_e.src);
                chk("taken", 32'(branch_is_taken_o), 32'(mon_e.taken));
                chk("call", 32'(branch_is_call_o), 32'(mon_e.call));
                chk("ret", 32'(branch_is_ret_o), 32'(mon_e.ret));
                chk("jmp", 32'(branch_is_jmp_o), 32'(mon_e.jmp));
                chk("target", branch_target_o, mon_e.tgt);
                chk("mispredict", 32'(branch_mispredict_o), 32'(mon_e.mis));
                chk("flush", 32'(flush_o), 32'(mon_e.mis));
                if (mon_e.mis || mon_e.taken)
                    chk("redirect", redirect_pc_o, mon_e.redir);
                chk("link", link_data_o, mon_e.link);
            end
        end else if (n_rst_i) begin
            chk("idle_flush", 32'(flush_o), 32'd0);
        end
    end

    task automatic idle_inputs();
        valid_i = 1'b0; is_branch_i = 1'b0; is_jal_i = 1'b0; is_jalr_i = 1'b0;
    endtask

    task automatic drive(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [4:0] rs1i, input logic [4:0] rdi, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic pt,
                         input logic [31:0] ppc);
        valid_i = 1'b1;
        is_branch_i = (kind == K_BR); is_jal_i = (kind == K_JAL); is_jalr_i = (kind == K_JALR);
        funct3_i = f3; pc_i = pc; rs1_idx_i = rs1i; rd_idx_i = rdi;
        rs1_data_i = a; rs2_data_i = b; imm_i = imm; pred_taken_i = pt; pred_pc_i = ppc;
    endtask

    task automatic issue(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [4:0] rs1i, input logic [4:0] rdi, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic pt,
                         input logic [31:0] ppc, input bit acc, input exp_t e);
        drive(kind, f3, pc, rs1i, rdi, a, b, imm, pt, ppc);
        if (acc) sb_q.push_back(e);
        @(posedge clk_i); #1;
        idle_inputs();
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_request"}, 32'(branch_request_o), 32'd0);
        chk({tag, "_source"}, branch_source_o, 32'd0);
        chk({tag, "_taken"}, 32'(branch_is_taken_o), 32'd0);
        chk({tag, "_cls"}, 32'({branch_is_call_o, branch_is_ret_o, branch_is_jmp_o}), 32'd0);
        chk({tag, "_target"}, branch_target_o, 32'd0);
        chk({tag, "_mispredict"}, 32'(branch_mispredict_o), 32'd0);
        chk({tag, "_flush"}, 32'(flush_o), 32'd0);
        chk({tag, "_redirect"}, redirect_pc_o, 32'd0);
        chk({tag, "_link"}, link_data_o, 32'd0);
        chk({tag, "_perf_br"}, perf_branch_cnt_o, 32'd0);
        chk({tag, "_perf_mis"}, perf_mispred_cnt_o, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100us, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_rst_i = 1'b0; stall_i = 1'b0;
        idle_inputs();
        funct3_i = 3'b000; pc_i = '0; rs1_idx_i = '0; rd_idx_i = '0;
        rs1_data_i = '0; rs2_data_i = '0; imm_i = '0; pred_taken_i = 1'b0; pred_pc_i = '0;
        cycles(3);
        check_zero("rst");
        @(negedge clk_i); n_rst_i = 1'b1;
        cycles(1);

        // T1..T3
        issue(K_BR, 3'b000, 32'h100, 5'd0, 5'd0, 32'd5, 32'd5, 32'h20, 1'b1, 32'h120, 1'b1,
              mk(32'h100, 1, 0, 0, 0, 32'h120, 0, 32'h120, 32'h104));
        issue(K_BR, 3'b100, 32'h300, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h304, 1'b1,
              mk(32'h300, 1, 0, 0, 0, 32'h340, 1, 32'h340, 32'h304));
        drive(K_BR, 3'b000, 32'h310, 5'd0, 5'd0, 32'd7, 32'd7, 32'h10, 1'b1, 32'h320);
        cycles(2);
        idle_inputs();
        issue(K_BR, 3'b110, 32'h400, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b1, 32'h440, 1'b1,
              mk(32'h400, 0, 0, 0, 0, 32'h440, 1, 32'h404, 32'h404));
`ifdef BRU_PERF_CNT_EN
        chk("perf_br_t1t3", perf_branch_cnt_o, 32'd3);
        chk("perf_mis_t1t3", perf_mispred_cnt_o, 32'd2);
`endif
        cycles(2);

        // T4 and further jump classification
        issue(K_JAL, 3'b000, 32'h200, 5'd0, 5'd1, 32'd0, 32'd0, 32'h100, 1'b1, 32'h300, 1'b1,
              mk(32'h200, 1, 1, 0, 0, 32'h300, 0, 32'h300, 32'h204));
        issue(K_JALR, 3'b000, 32'h300, 5'd1, 5'd0, 32'h205, 32'd0, 32'd0, 1'b1, 32'h204, 1'b1,
              mk(32'h300, 1, 0, 1, 0, 32'h204, 0, 32'h204, 32'h304));
        issue(K_JAL, 3'b000, 32'h500, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFF8, 1'b1, 32'h4F8, 1'b1,
              mk(32'h500, 1, 0, 0, 1, 32'h4F8, 0, 32'h4F8, 32'h504));
        issue(K_JALR, 3'b000, 32'h520, 5'd1, 5'd5, 32'h1000, 32'd0, 32'h11, 1'b1, 32'h1010, 1'b1,
              mk(32'h520, 1, 1, 0, 0, 32'h1010, 0, 32'h1010, 32'h524));
        issue(K_BR, 3'b001, 32'hFFFF_FFF0, 5'd0, 5'd0, 32'd1, 32'd2, 32'h20, 1'b1, 32'h10, 1'b1,
              mk(32'hFFFF_FFF0, 1, 0, 0, 0, 32'h10, 0, 32'h10, 32'hFFFF_FFF4));
        issue(K_BR, 3'b101, 32'h600, 5'd0, 5'd0, 32'h8000_0000, 32'd0, 32'd8, 1'b0, 32'd0, 1'b1,
              mk(32'h600, 0, 0, 0, 0, 32'h608, 0, 32'h604, 32'h604));
        issue(K_BR, 3'b111, 32'h700, 5'd0, 5'd0, 32'h8000_0000, 32'd0, 32'h10, 1'b1, 32'h710, 1'b1,
              mk(32'h700, 1, 0, 0, 0, 32'h710, 0, 32'h710, 32'h704));

        // Illegal conditions and multiple op flags are never accepted
        issue(K_BR, 3'b010, 32'h740, 5'd0, 5'd0, 32'd1, 32'd1, 32'h8, 1'b1, 32'd0, 1'b0,
              mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        issue(K_BR, 3'b011, 32'h744, 5'd0, 5'd0, 32'd1, 32'd2, 32'h8, 1'b1, 32'd0, 1'b0,
              mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(K_BR, 3'b000, 32'h748, 5'd0, 5'd1, 32'd1, 32'd1, 32'h8, 1'b0, 32'd0);
        is_jal_i = 1'b1;
        cycles(1);
        idle_inputs();

        // Taken with correct direction but wrong predicted target
        issue(K_BR, 3'b000, 32'h780, 5'd0, 5'd0, 32'd4, 32'd4, 32'h20, 1'b1, 32'h790, 1'b1,
              mk(32'h780, 1, 0, 0, 0, 32'h7A0, 1, 32'h7A0, 32'h784));
        cycles(2);

        // T5: stalled instruction produces a single update
        drive(K_BR, 3'b000, 32'h800, 5'd0, 5'd0, 32'd3, 32'd3, 32'd4, 1'b1, 32'h804);
        stall_i = 1'b1;
        sb_q.push_back(mk(32'h800, 1, 0, 0, 0, 32'h804, 0, 32'h804, 32'h804));
        for (int i = 0; i < 3; i++) begin
            cycles(1);
            chk("stall_no_req", 32'(branch_request_o), 32'd0);
        end
        stall_i = 1'b0;
        cycles(1);
        idle_inputs();
        cycles(1);
        chk("req_one_pulse", 32'(branch_request_o), 32'd0);

        // T5: shadow counter frozen while stalled
        issue(K_BR, 3'b001, 32'h900, 5'd0, 5'd0, 32'd9, 32'd9, 32'h10, 1'b1, 32'h910, 1'b1,
              mk(32'h900, 0, 0, 0, 0, 32'h910, 1, 32'h904, 32'h904));
        drive(K_BR, 3'b000, 32'hA00, 5'd0, 5'd0, 32'd6, 32'd6, 32'd8, 1'b1, 32'hA08);
        sb_q.push_back(mk(32'hA00, 1, 0, 0, 0, 32'hA08, 0, 32'hA08, 32'hA04));
        stall_i = 1'b1;
        cycles(3);
        stall_i = 1'b0;
        cycles(1);
        chk("shadow_frozen_a", 32'(branch_request_o), 32'd0);
        cycles(1);
        chk("shadow_frozen_b", 32'(branch_request_o), 32'd0);
        cycles(1);
        chk("shadow_exit_accept", 32'(branch_request_o), 32'd1);
        idle_inputs();

        // T6: async reset during the shadow window
        issue(K_BR, 3'b000, 32'hB00, 5'd0, 5'd0, 32'd1, 32'd2, 32'h40, 1'b1, 32'hB40, 1'b1,
              mk(32'hB00, 0, 0, 0, 0, 32'hB40, 1, 32'hB04, 32'hB04));
        @(negedge clk_i); #1;
        n_rst_i = 1'b0;
        #1;
        check_zero("async_rst");
        @(posedge clk_i);
        @(negedge clk_i);
        n_rst_i = 1'b1;
        issue(K_BR, 3'b110, 32'hC00, 5'd0, 5'd0, 32'd1, 32'd2, 32'h30, 1'b1, 32'hC30, 1'b1,
              mk(32'hC00, 1, 0, 0, 0, 32'hC30, 0, 32'hC30, 32'hC04));
`ifdef BRU_PERF_CNT_EN
        chk("perf_br_end", perf_branch_cnt_o, 32'd1);
        chk("perf_mis_end", perf_mispred_cnt_o, 32'd0);
`else
        chk("perf_br_tied", perf_branch_cnt_o, 32'd0);
        chk("perf_mis_tied", perf_mispred_cnt_o, 32'd0);
`endif
        cycles(3);
        @(negedge clk_i); #1;
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
